prog_loader: RTL and testbench

- Serial program/register loader inside tt_um_tiny_processor, directly downstream of the bench/board driver.
- Consumes the driver's mode pair (uio_in[1:0]) and serial data line (uio_in[4]), and deframes 8-bit words.
- Issues sequential write strobes into the instruction memory or register file.
- Reports completion on done (uio_out[2]) back to the driver.

---
 rtl/tp_pkg.sv | 17 +
 rtl/serial_deframer.sv | 41 ++++
 rtl/prog_loader.sv | 84 ++++++++
 tb/tb_prog_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tp_pkg.sv
// tp_pkg: shared types and constants for the tiny processor core, driver and loader.
package tp_pkg;
    localparam int WORD_W = 8;
    typedef enum logic [1:0] {
        MODE_IDLE     = 2'b00,
        MODE_LD_INSTR = 2'b01,
        MODE_LD_REG   = 2'b10,
        MODE_RUN      = 2'b11
    } mode_e;
    typedef enum logic [2:0] {
        LS_IDLE       = 3'd0,
        LS_WAIT_START = 3'd1,
        LS_SHIFT      = 3'd2,
        LS_WRITE      = 3'd3,
        LS_DONE       = 3'd4
    } loader_state_e;
endpackage

// File: rtl/serial_deframer.sv
// serial_deframer: start-bit detect, MSB-first WORD_W shift and a one-cycle word_valid pulse.
module serial_deframer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              sdi_i,
    output logic              last_o,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);
    localparam int CNT_W = WORD_W > 1 ? $clog2(WORD_W) : 1;
    logic              shifting_q, shifting_d, valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    assign last_o       = shifting_q && cnt_q == CNT_W'(WORD_W - 1);
    assign word_valid_o = valid_q;
    assign word_o       = word_q;
    // A start bit during the valid cycle is ignored so frames need one idle gap.
    always_comb begin
        shifting_d = !clr_i && (shifting_q ? !last_o : en_i && sdi_i && !valid_q);
        cnt_d      = (!clr_i && shifting_q && !last_o) ? cnt_q + 1'b1 : '0;
        valid_d    = !clr_i && last_o;
        word_d     = shifting_q ? {word_q[WORD_W-2:0], sdi_i} : word_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifting_q <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            word_q     <= '0;
        end else begin
            shifting_q <= shifting_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: serial loader writing sequential words into instruction memory or register file.
module prog_loader #(
    parameter int N_INSTR = 16,
    parameter int N_REGS  = 16,
    parameter int WORD_W  = tp_pkg::WORD_W,
    localparam int ADDR_W = $clog2(N_INSTR > N_REGS ? N_INSTR : N_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic              sdi_i,
    output logic              wr_en_o,
    output logic              wr_sel_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WORD_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              run_o
);
    import tp_pkg::*;
    loader_state_e     state_q, state_d;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_q, addr_d, last_addr;
    logic              sel_q, sel_d, mode_chg, abort, last_bit, word_valid;
    logic [WORD_W-1:0] word;
    serial_deframer #(.WORD_W(WORD_W)) u_deframer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (state_q == LS_WAIT_START),
        .clr_i        (abort || state_q == LS_IDLE || state_q == LS_DONE),
        .sdi_i        (sdi_i),
        .last_o       (last_bit),
        .word_valid_o (word_valid),
        .word_o       (word)
    );
    always_comb begin
        mode_chg  = mode_i != mode_q;
        abort     = mode_chg && state_q != LS_IDLE;
        last_addr = sel_q ? ADDR_W'(N_REGS - 1) : ADDR_W'(N_INSTR - 1);
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        case (state_q)
            LS_IDLE: if (mode_i == MODE_LD_INSTR || mode_i == MODE_LD_REG) begin
                state_d = LS_WAIT_START;
                addr_d  = '0;
                sel_d   = mode_i[1];
            end
            LS_WAIT_START: state_d = sdi_i ? LS_SHIFT : LS_WAIT_START;
            LS_SHIFT:      state_d = last_bit ? LS_WRITE : LS_SHIFT;
            LS_WRITE: begin
                state_d = addr_q == last_addr ? LS_DONE : LS_WAIT_START;
                addr_d  = addr_q == last_addr ? addr_q : addr_q + 1'b1;
            end
            LS_DONE: state_d = LS_DONE;
            default: state_d = LS_IDLE;
        endcase
        // Any mode change outside IDLE drops the partial word and restarts from address 0.
        if (abort) begin
            state_d = LS_IDLE;
            addr_d  = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LS_IDLE;
            mode_q  <= 2'b00;
            addr_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_i;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
        end
    end
    assign wr_en_o   = state_q == LS_WRITE && word_valid;
    assign wr_sel_o  = sel_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = word;
    assign busy_o    = state_q != LS_IDLE && state_q != LS_DONE;
    assign done_o    = state_q == LS_DONE;
    assign run_o     = mode_q == MODE_RUN;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frame stimulus checked against a transaction-level loader model.
module tb_prog_loader;
    localparam int N = 16;
    logic       clk = 1'b0, rst_n = 1'b0, sdi_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic       wr_en_o, wr_sel_o, busy_o, done_o, run_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic [31:0] cyc = 0;
    int n_chk = 0, n_err = 0;
    logic [31:0] got_q[$], exp_q[$];
    logic [1:0] m_mode = 2'b00;
    bit m_act = 0, m_done = 0, m_sel = 0;
    int m_cnt = 0;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .sdi_i(sdi_i),
        .wr_en_o(wr_en_o), .wr_sel_o(wr_sel_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .done_o(done_o), .run_o(run_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write is stamped with the cycle it is seen in.
    always @(negedge clk) begin
        if (wr_en_o) got_q.push_back({cyc[18:0], wr_sel_o, wr_addr_o, wr_data_o});
        if (rst_n) chk("excl", {31'd0, busy_o & done_o}, 32'd0);
    end

    task automatic drv(input logic b);
        @(posedge clk);
        #1 sdi_i = b;
    endtask

    task automatic settle();
        repeat (3) drv(1'b0);
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode_i = m;
        if (m != m_mode) begin
            m_act  = (m == 2'b01 || m == 2'b10);
            m_sel  = m[1];
            m_cnt  = 0;
            m_done = 0;
        end
        m_mode = m;
    endtask

    task automatic send_frame(input logic [7:0] d, input int gap);
        logic [18:0] ec;
        drv(1'b1);
        for (int i = 7; i >= 0; i--) drv(d[i]);
        ec = 19'(cyc + 1);
        if (m_act && !m_done) begin
            exp_q.push_back({ec, m_sel, 4'(m_cnt), d});
            m_cnt++;
            if (m_cnt == N) m_done = 1;
        end
        repeat (gap) drv(1'b0);
    endtask

    task automatic status(input string tag);
        drv(1'b0);
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, busy_o}, {31'd0, m_act && !m_done});
        chk({tag, "_done"}, {31'd0, done_o}, {31'd0, m_done});
        chk({tag, "_run"}, {31'd0, run_o}, {31'd0, m_mode == 2'b11});
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) chk({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1 chk("reset_out", {15'd0, wr_en_o, wr_sel_o, wr_addr_o, wr_data_o, busy_o, done_o, run_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        // Full instruction load with data equal to the address.
        set_mode(2'b01);
        settle();
        for (int k = 0; k < N; k++) send_frame(8'(k), $urandom_range(1, 3));
        status("full");
        compare("full");
        // Frames after DONE are ignored; run mode clears done.
        send_frame(8'($urandom), 2);
        send_frame(8'($urandom), 2);
        status("extra");
        compare("extra");
        set_mode(2'b11);
        status("run");
        settle();
        // Register load with minimum inter-frame gap.
        set_mode(2'b00);
        settle();
        set_mode(2'b10);
        settle();
        send_frame(8'hA5, 1);
        send_frame(8'h3C, 1);
        for (int k = 2; k < N; k++) send_frame(8'($urandom), 1);
        status("regs");
        compare("regs");
        // Abort mid-frame, then restart at address 0.
        set_mode(2'b00);
        settle();
        set_mode(2'b01);
        settle();
        send_frame(8'($urandom), $urandom_range(1, 3));
        send_frame(8'($urandom), $urandom_range(1, 3));
        drv(1'b1);
        repeat (4) drv(1'($urandom_range(0, 1)));
        set_mode(2'b00);
        drv(1'b0);
        @(negedge clk);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_addr", {28'd0, wr_addr_o}, 32'd0);
        settle();
        set_mode(2'b01);
        settle();
        send_frame(8'($urandom), 2);
        status("abort");
        compare("abort");
        // Long idle line, then a zero-data frame.
        repeat (50) drv(1'b0);
        status("glitch_idle");
        compare("glitch_idle");
        send_frame(8'h00, 2);
        status("glitch");
        compare("glitch");
        // Asynchronous reset in the middle of a frame.
        drv(1'b1);
        repeat (3) drv(1'($urandom_range(0, 1)));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {15'd0, wr_en_o, wr_sel_o, wr_addr_o, wr_data_o, busy_o, done_o, run_o}, 32'd0);
        mode_i = 2'b00;
        m_mode = 2'b00;
        m_act  = 0;
        m_done = 0;
        m_cnt  = 0;
        sdi_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        status("rst");
        compare("rst");
        // Random mix of frames and mode changes.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 7) send_frame(8'($urandom), $urandom_range(1, 3));
            else begin
                set_mode(2'($urandom_range(0, 3)));
                settle();
            end
            status("rnd");
        end
        compare("rnd");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
